// File: rtl/irq_trap_seq_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, instruction
// encodings, cause codes, mstatus bit positions and the sequencer state type.
package irq_trap_seq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL    = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
    localparam logic [31:0] CAUSE_EXT_BASE = 32'h8000_0010;
    localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;

    localparam int unsigned MST_MIE    = 3;
    localparam int unsigned MST_MPIE   = 7;
    localparam int unsigned MST_MPP_LO = 11;
    localparam int unsigned MST_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MSTATUS,
        ST_W_MCAUSE,
        ST_MRET_STATUS,
        ST_REDIRECT
    } state_e;

endpackage

// File: rtl/irq_trap_seq_prio_enc.sv
// Lowest-index-wins priority encoder for the external interrupt lines.
module irq_prio_enc #(
    parameter  int unsigned W  = 8,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req_i[i] && !valid_o) begin
                valid_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_trap_seq.sv
// Machine-mode trap sequencer: serialises mepc/mstatus/mcause writes, then redirects.
// Optional machine timer enabled with `define IRQ_TRAP_SEQ_MTIMER_EN.
module irq_trap_seq
    import irq_trap_seq_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12,
    parameter int unsigned INT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [XLEN-1:0]   jump_addr_i,
    input  logic [INT_W-1:0]  int_i,
    input  logic [XLEN-1:0]   csr_mtvec_i,
    input  logic [XLEN-1:0]   csr_mepc_i,
    input  logic [XLEN-1:0]   csr_mstatus_i,
`ifdef IRQ_TRAP_SEQ_MTIMER_EN
    input  logic              tcmp_we_i,
    input  logic [XLEN-1:0]   tcmp_wdata_i,
`endif
    output logic              hold_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              int_assert_o,
    output logic [XLEN-1:0]   int_addr_o
);

    localparam int unsigned IW = (INT_W > 1) ? $clog2(INT_W) : 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   mst_q, mst_d;
    logic              hold_q, hold_d;
    logic              we_q, we_d;
    logic [CSR_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              assert_q, assert_d;
    logic [XLEN-1:0]   iaddr_q, iaddr_d;

    logic              irq_valid;
    logic [IW-1:0]     irq_idx;
    logic              mie;
    logic              tmr_pend;
    logic [XLEN-1:0]   irq_epc;
    logic [XLEN-1:0]   trap_mst;
    logic [XLEN-1:0]   mret_mst;

    irq_prio_enc #(.W(INT_W)) u_prio (
        .req_i   (int_i),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

`ifdef IRQ_TRAP_SEQ_MTIMER_EN
    logic [31:0] mtime_q, mtimecmp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '0;
        end else begin
            mtime_q <= mtime_q + 32'd1;
            if (tcmp_we_i) mtimecmp_q <= tcmp_wdata_i[31:0];
        end
    end

    // Compare uses registered mtimecmp, so a same-cycle write sees the old value.
    assign tmr_pend = (mtimecmp_q != '0) && (mtime_q >= mtimecmp_q);
`else
    assign tmr_pend = 1'b0;
`endif

    assign mie     = csr_mstatus_i[MST_MIE];
    assign irq_epc = jump_flag_i ? jump_addr_i : inst_addr_i;

    always_comb begin
        trap_mst                         = mst_q;
        trap_mst[MST_MPIE]               = mst_q[MST_MIE];
        trap_mst[MST_MIE]                = 1'b0;
        trap_mst[MST_MPP_HI:MST_MPP_LO]  = 2'b11;
        mret_mst                         = csr_mstatus_i;
        mret_mst[MST_MIE]                = csr_mstatus_i[MST_MPIE];
        mret_mst[MST_MPIE]               = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        mst_d   = mst_q;
        unique case (state_q)
            ST_IDLE: begin
                if (inst_i == XLEN'(INST_ECALL) || inst_i == XLEN'(INST_EBREAK)) begin
                    epc_d   = inst_addr_i;
                    cause_d = (inst_i == XLEN'(INST_ECALL)) ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_EBREAK);
                    mst_d   = csr_mstatus_i;
                    state_d = ST_W_MEPC;
                end else if (inst_i == XLEN'(INST_MRET)) begin
                    state_d = ST_MRET_STATUS;
                end else if (mie && tmr_pend) begin
                    epc_d   = irq_epc;
                    cause_d = XLEN'(CAUSE_TIMER);
                    mst_d   = csr_mstatus_i;
                    state_d = ST_W_MEPC;
                end else if (mie && irq_valid) begin
                    epc_d   = irq_epc;
                    cause_d = XLEN'(CAUSE_EXT_BASE) + XLEN'(irq_idx);
                    mst_d   = csr_mstatus_i;
                    state_d = ST_W_MEPC;
                end
            end
            ST_W_MEPC:      state_d = ST_W_MSTATUS;
            ST_W_MSTATUS:   state_d = ST_W_MCAUSE;
            ST_W_MCAUSE:    state_d = ST_REDIRECT;
            ST_MRET_STATUS: state_d = ST_REDIRECT;
            ST_REDIRECT:    state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state.
    always_comb begin
        hold_d   = (state_d != ST_IDLE);
        we_d     = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        assert_d = 1'b0;
        iaddr_d  = '0;
        unique case (state_d)
            ST_W_MEPC: begin
                we_d    = 1'b1;
                waddr_d = CSR_AW'(CSR_MEPC);
                wdata_d = epc_d;
            end
            ST_W_MSTATUS: begin
                we_d    = 1'b1;
                waddr_d = CSR_AW'(CSR_MSTATUS);
                wdata_d = trap_mst;
            end
            ST_W_MCAUSE: begin
                we_d    = 1'b1;
                waddr_d = CSR_AW'(CSR_MCAUSE);
                wdata_d = cause_q;
            end
            ST_MRET_STATUS: begin
                we_d    = 1'b1;
                waddr_d = CSR_AW'(CSR_MSTATUS);
                wdata_d = mret_mst;
            end
            ST_REDIRECT: begin
                assert_d = 1'b1;
                iaddr_d  = (state_q == ST_MRET_STATUS) ? csr_mepc_i : csr_mtvec_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            mst_q    <= '0;
            hold_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            assert_q <= 1'b0;
            iaddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            mst_q    <= mst_d;
            hold_q   <= hold_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            assert_q <= assert_d;
            iaddr_q  <= iaddr_d;
        end
    end

    assign hold_o       = hold_q;
    assign csr_we_o     = we_q;
    assign csr_waddr_o  = waddr_q;
    assign csr_wdata_o  = wdata_q;
    assign int_assert_o = assert_q;
    assign int_addr_o   = iaddr_q;

endmodule

// File: tb/tb_irq_trap_seq.sv
// Directed bench for irq_trap_seq; timer scenario built when IRQ_TRAP_SEQ_MTIMER_EN is defined.
module tb_irq_trap_seq;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_i = NOP, inst_addr_i = '0, jump_addr_i = '0;
    logic        jump_flag_i = 1'b0;
    logic [7:0]  int_i = '0;
    logic [31:0] csr_mtvec_i = 32'h80, csr_mepc_i = '0, csr_mstatus_i = '0;
`ifdef IRQ_TRAP_SEQ_MTIMER_EN
    logic        tcmp_we_i = 1'b0;
    logic [31:0] tcmp_wdata_i = '0;
`endif
    logic        hold_o, csr_we_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    int checks = 0;
    int errors = 0;

    irq_trap_seq #(.XLEN(32), .CSR_AW(12), .INT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .int_i         (int_i),
        .csr_mtvec_i   (csr_mtvec_i),
        .csr_mepc_i    (csr_mepc_i),
        .csr_mstatus_i (csr_mstatus_i),
`ifdef IRQ_TRAP_SEQ_MTIMER_EN
        .tcmp_we_i     (tcmp_we_i),
        .tcmp_wdata_i  (tcmp_wdata_i),
`endif
        .hold_o        (hold_o),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .int_assert_o  (int_assert_o),
        .int_addr_o    (int_addr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output vector: {hold, we, waddr, wdata, assert, int_addr}.
    function automatic logic [78:0] pk(input logic h, input logic we, input logic [11:0] a,
                                       input logic [31:0] d, input logic as, input logic [31:0] ia);
        return {h, we, a, d, as, ia};
    endfunction

    // Address/data fields only matter while their strobe is high.
    function automatic logic [78:0] obs();
        return {hold_o, csr_we_o, csr_we_o ? csr_waddr_o : 12'h0, csr_we_o ? csr_wdata_o : 32'h0,
                int_assert_o, int_assert_o ? int_addr_o : 32'h0};
    endfunction

    task automatic test_reset();
        logic [78:0] raw;
        rst = 1'b1;
        #2 rst = 1'b0;
        #3;
        raw = {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
        checks++;
        if (raw !== '0) begin errors++; $display("FAIL reset_async: got %h expected 0", raw); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        raw = {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
        checks++;
        if (raw !== '0) begin errors++; $display("FAIL reset_release: got %h expected 0", raw); end
    endtask

    task automatic test_ecall();
        logic [78:0] exp [5];
        logic [78:0] got;
        exp = '{pk(1,1,12'h341,32'h100,0,0), pk(1,1,12'h300,32'h1880,0,0), pk(1,1,12'h342,32'd11,0,0),
                pk(1,0,0,0,1,32'h80), pk(0,0,0,0,0,0)};
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst_i = NOP;
            got = obs();
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL ecall N+%0d: got %h expected %h", i+1, got, exp[i]); end
        end
    endtask

    task automatic test_irq();
        logic [78:0] exp [5];
        logic [78:0] got;
        exp = '{pk(1,1,12'h341,32'h200,0,0), pk(1,1,12'h300,32'h1880,0,0), pk(1,1,12'h342,32'h8000_0012,0,0),
                pk(1,0,0,0,1,32'h80), pk(0,0,0,0,0,0)};
        @(negedge clk);
        inst_i = NOP; inst_addr_i = 32'h300; csr_mstatus_i = 32'h8;
        int_i = 8'b0010_0100; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            int_i = '0; jump_flag_i = 1'b0;
            got = obs();
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL irq N+%0d: got %h expected %h", i+1, got, exp[i]); end
        end
    endtask

    task automatic test_irq_masked();
        logic [78:0] got;
        @(negedge clk);
        csr_mstatus_i = 32'h0; int_i = 8'b0010_0100; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = obs();
            checks++;
            if (got !== '0) begin errors++; $display("FAIL irq_masked N+%0d: got %h expected 0", i+1, got); end
        end
        int_i = '0; jump_flag_i = 1'b0;
    endtask

    task automatic test_mret();
        logic [78:0] exp [3];
        logic [78:0] got;
        exp = '{pk(1,1,12'h300,32'h1888,0,0), pk(1,0,0,0,1,32'h104), pk(0,0,0,0,0,0)};
        @(negedge clk);
        inst_i = MRET; csr_mstatus_i = 32'h1880; csr_mepc_i = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inst_i = NOP;
            got = obs();
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL mret N+%0d: got %h expected %h", i+1, got, exp[i]); end
        end
    endtask

    // mret wins over a pending interrupt; the interrupt is taken from IDLE afterwards.
    task automatic test_mret_irq();
        logic [78:0] exp [8];
        logic [78:0] got;
        exp = '{pk(1,1,12'h300,32'h1888,0,0), pk(1,0,0,0,1,32'h104), pk(0,0,0,0,0,0),
                pk(1,1,12'h341,32'h50,0,0), pk(1,1,12'h300,32'h1880,0,0), pk(1,1,12'h342,32'h8000_0010,0,0),
                pk(1,0,0,0,1,32'h80), pk(0,0,0,0,0,0)};
        @(negedge clk);
        inst_i = MRET; inst_addr_i = 32'h50; csr_mstatus_i = 32'h1888; csr_mepc_i = 32'h104; int_i = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inst_i = NOP;
            if (i == 3) int_i = '0;
            got = obs();
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL mret_irq N+%0d: got %h expected %h", i+1, got, exp[i]); end
        end
    endtask

    task automatic test_ecall_irq();
        logic [78:0] exp [5];
        logic [78:0] got;
        exp = '{pk(1,1,12'h341,32'h120,0,0), pk(1,1,12'h300,32'h1880,0,0), pk(1,1,12'h342,32'd11,0,0),
                pk(1,0,0,0,1,32'h80), pk(0,0,0,0,0,0)};
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'h120; csr_mstatus_i = 32'h8; int_i = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst_i = NOP; int_i = '0;
            got = obs();
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL ecall_irq N+%0d: got %h expected %h", i+1, got, exp[i]); end
        end
    endtask

    // inst_i stays ecall during the sequence (ignored), then ebreak is taken straight from IDLE.
    task automatic test_back_to_back();
        logic [78:0] exp [9];
        logic [78:0] got;
        exp = '{pk(1,1,12'h341,32'h100,0,0), pk(1,1,12'h300,32'h1880,0,0), pk(1,1,12'h342,32'd11,0,0),
                pk(1,0,0,0,1,32'h80), pk(0,0,0,0,0,0), pk(1,1,12'h341,32'h200,0,0),
                pk(1,1,12'h300,32'h1880,0,0), pk(1,1,12'h342,32'd3,0,0), pk(1,0,0,0,1,32'h80)};
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            got = obs();
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL back_to_back N+%0d: got %h expected %h", i+1, got, exp[i]); end
            if (i == 3) begin inst_i = EBREAK; inst_addr_i = 32'h200; end
            if (i == 5) inst_i = NOP;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [78:0] got;
        logic [78:0] raw;
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8;
        @(negedge clk);
        inst_i = NOP;
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== pk(1,1,12'h300,32'h1880,0,0)) begin
            errors++; $display("FAIL reset_mid pre: got %h expected %h", got, pk(1,1,12'h300,32'h1880,0,0));
        end
        #1 rst = 1'b0;
        #1;
        raw = {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
        checks++;
        if (raw !== '0) begin errors++; $display("FAIL reset_mid abort: got %h expected 0", raw); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_mid idle: got %h expected 0", got); end
        inst_i = MRET; csr_mstatus_i = 32'h1880; csr_mepc_i = 32'h104;
        @(negedge clk);
        inst_i = NOP;
        got = obs();
        checks++;
        if (got !== pk(1,1,12'h300,32'h1888,0,0)) begin
            errors++; $display("FAIL reset_mid restart: got %h expected %h", got, pk(1,1,12'h300,32'h1888,0,0));
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef IRQ_TRAP_SEQ_MTIMER_EN
    task automatic test_timer();
        logic [78:0] got;
        int k;
        int hold_seen;
        @(negedge clk);
        rst = 1'b0; inst_i = NOP; inst_addr_i = 32'h40; csr_mstatus_i = 32'h8; int_i = '0;
        @(negedge clk);
        rst = 1'b1; tcmp_we_i = 1'b1; tcmp_wdata_i = 32'd10;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            tcmp_we_i = 1'b0;
            if (csr_we_o) break;
        end
        checks++;
        if (k != 11) begin errors++; $display("FAIL timer latency: got %0d expected 11", k); end
        got = obs();
        checks++;
        if (got !== pk(1,1,12'h341,32'h40,0,0)) begin
            errors++; $display("FAIL timer mepc: got %h expected %h", got, pk(1,1,12'h341,32'h40,0,0));
        end
        csr_mstatus_i = 32'h0;
        repeat (2) @(negedge clk);
        got = obs();
        checks++;
        if (got !== pk(1,1,12'h342,32'h8000_0007,0,0)) begin
            errors++; $display("FAIL timer mcause: got %h expected %h", got, pk(1,1,12'h342,32'h8000_0007,0,0));
        end
        repeat (2) @(negedge clk);
        tcmp_we_i = 1'b1; tcmp_wdata_i = 32'd0;
        @(negedge clk);
        tcmp_we_i = 1'b0; csr_mstatus_i = 32'h8;
        hold_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (hold_o !== 1'b0) hold_seen++;
        end
        checks++;
        if (hold_seen != 0) begin errors++; $display("FAIL timer_zero: got %0d hold cycles expected 0", hold_seen); end
        csr_mstatus_i = 32'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_ecall();
        test_irq();
        test_irq_masked();
        test_mret();
        test_mret_irq();
        test_ecall_irq();
        test_back_to_back();
        test_reset_mid();
`ifdef IRQ_TRAP_SEQ_MTIMER_EN
        test_timer();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
